// File: rtl/cp0_exc_ctrl_pkg.sv
// CP0 constants shared by the exception controller, decode and forwarding:
// register numbers, field positions, handler vector, PRId and packing helpers.
package cp0_exc_ctrl_pkg;

    // CP0 register numbers
    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    // SR field positions
    localparam int SR_IM_HI   = 15;
    localparam int SR_IM_LO   = 10;
    localparam int SR_EXL_BIT = 1;
    localparam int SR_IE_BIT  = 0;

    // Cause field positions
    localparam int CAUSE_BD_BIT = 31;
    localparam int CAUSE_IP_HI  = 15;
    localparam int CAUSE_IP_LO  = 10;
    localparam int CAUSE_EXC_HI = 6;
    localparam int CAUSE_EXC_LO = 2;

    localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
    localparam logic [31:0] PRID_VALUE = 32'h2022_1118;

    // Handler FSM; the state bit is SR.EXL itself
    typedef enum logic {
        ST_NORMAL  = 1'b0,
        ST_HANDLER = 1'b1
    } exl_state_e;

    // Build the architectural SR word; unimplemented bits read 0
    function automatic logic [31:0] pack_sr(input logic [5:0] im, input logic exl,
                                            input logic ie);
        logic [31:0] w;
        w = '0;
        w[SR_IM_HI:SR_IM_LO] = im;
        w[SR_EXL_BIT]        = exl;
        w[SR_IE_BIT]         = ie;
        return w;
    endfunction

    // Build the architectural Cause word; unimplemented bits read 0
    function automatic logic [31:0] pack_cause(input logic bd, input logic [5:0] ip,
                                               input logic [4:0] exc);
        logic [31:0] w;
        w = '0;
        w[CAUSE_BD_BIT]               = bd;
        w[CAUSE_IP_HI:CAUSE_IP_LO]    = ip;
        w[CAUSE_EXC_HI:CAUSE_EXC_LO]  = exc;
        return w;
    endfunction

endpackage

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt controller: holds SR, Cause, EPC, raises the
// flush/redirect request for the M-stage instruction and services mtc0/mfc0.
module cp0_exc_ctrl
    import cp0_exc_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  M_ExcCode,
    input  logic [31:0] M_PC,
    input  logic        M_BD,
    input  logic        M_Eret,
    input  logic [5:0]  HWInt,
    input  logic        M_CP0We,
    input  logic [4:0]  M_CP0Addr,
    input  logic [31:0] M_CP0WD,
    output logic [31:0] CP0RD,
    output logic        Req,
    output logic [31:0] ReqPC,
    output logic [31:0] EPCOut
);

    exl_state_e  state;
    logic [5:0]  sr_im;
    logic        sr_ie;
    logic        sr_exl;
    logic        cause_bd;
    logic [5:0]  cause_ip;
    logic [4:0]  cause_exc;
    logic [31:0] epc;

    logic        int_req;
    logic        exc_req;
    logic [31:0] epc_target;

    assign sr_exl = (state == ST_HANDLER);
    assign EPCOut = epc;

    // Request/priority logic: interrupts and exceptions both blocked while EXL=1
    always_comb begin
        // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
        int_req    = (|(HWInt & sr_im)) & sr_ie & ~sr_exl;
        exc_req    = (M_ExcCode != 5'd0) & ~sr_exl;
        Req        = int_req | exc_req;
        epc_target = M_BD ? (M_PC - 32'd4) : M_PC;
        if (Req)
            ReqPC = HANDLER_PC;
        else if (M_Eret)
            ReqPC = epc;
        else
            ReqPC = '0;
    end

    // mfc0 read port: always the registered (pre-write) values
    always_comb begin
        case (M_CP0Addr)
            CP0_SR:    CP0RD = pack_sr(sr_im, sr_exl, sr_ie);
            CP0_CAUSE: CP0RD = pack_cause(cause_bd, cause_ip, cause_exc);
            CP0_EPC:   CP0RD = epc;
            CP0_PRID:  CP0RD = PRID_VALUE;
            default:   CP0RD = '0;
        endcase
    end

    // Handler FSM plus SR/Cause/EPC updates; a faulting instruction's mtc0 never commits
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset) begin
            state     <= ST_NORMAL;
            sr_im     <= '0;
            sr_ie     <= 1'b0;
            cause_bd  <= 1'b0;
            cause_ip  <= '0;
            cause_exc <= '0;
            epc       <= '0;
        end else begin
            cause_ip <= HWInt;
            if (Req) begin
                state     <= ST_HANDLER;
                cause_exc <= int_req ? 5'd0 : M_ExcCode;
                cause_bd  <= M_BD;
                epc       <= {epc_target[31:2], 2'b00};
            end else begin
                if (M_Eret)
                    state <= ST_NORMAL;
                if (M_CP0We) begin
                    if (M_CP0Addr == CP0_SR) begin
                        sr_im <= M_CP0WD[SR_IM_HI:SR_IM_LO];
                        sr_ie <= M_CP0WD[SR_IE_BIT];
                        state <= M_CP0WD[SR_EXL_BIT] ? ST_HANDLER : ST_NORMAL;
                    end else if (M_CP0Addr == CP0_EPC) begin
                        epc <= {M_CP0WD[31:2], 2'b00};
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Self-checking bench for cp0_exc_ctrl: directed scenarios plus a randomized
// run compared against a word-level model of the CP0 registers.
module tb_cp0_exc_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  M_ExcCode;
    logic [31:0] M_PC;
    logic        M_BD;
    logic        M_Eret;
    logic [5:0]  HWInt;
    logic        M_CP0We;
    logic [4:0]  M_CP0Addr;
    logic [31:0] M_CP0WD;
    logic [31:0] CP0RD;
    logic        Req;
    logic [31:0] ReqPC;
    logic [31:0] EPCOut;

    int total = 0;
    int bad   = 0;

    // Reference model: architectural register words
    logic [31:0] m_sr, m_cause, m_epc;

    cp0_exc_ctrl dut (
        .clk(clk), .reset(reset), .M_ExcCode(M_ExcCode), .M_PC(M_PC), .M_BD(M_BD),
        .M_Eret(M_Eret), .HWInt(HWInt), .M_CP0We(M_CP0We), .M_CP0Addr(M_CP0Addr),
        .M_CP0WD(M_CP0WD), .CP0RD(CP0RD), .Req(Req), .ReqPC(ReqPC), .EPCOut(EPCOut)
    );

    always #5 clk = ~clk;

    function automatic logic model_int();
        return ((HWInt & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
    endfunction

    function automatic logic model_req();
        return model_int() || ((M_ExcCode != 5'd0) && !m_sr[1]);
    endfunction

    function automatic logic [31:0] model_reqpc();
        if (model_req()) return 32'h0000_4180;
        if (M_Eret)      return m_epc;
        return 32'h0;
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a);
        case (a)
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            5'd15:   return 32'h2022_1118;
            default: return 32'h0;
        endcase
    endfunction

    task automatic idle();
        reset = 1'b1; M_ExcCode = '0; M_PC = '0; M_BD = 1'b0; M_Eret = 1'b0;
        HWInt = '0; M_CP0We = 1'b0; M_CP0Addr = '0; M_CP0WD = '0;
    endtask

    // Advance one clock, applying the architectural rules to the model
    task automatic tick();
        logic [31:0] n_sr, n_cause, n_epc, tgt;
        logic        r, i;
        n_sr = m_sr; n_cause = m_cause; n_epc = m_epc;
        r = model_req(); i = model_int();
        if (!reset) begin
            n_sr = 0; n_cause = 0; n_epc = 0;
        end else begin
            n_cause = (n_cause & ~32'h0000_FC00) | (32'(HWInt) << 10);
            if (r) begin
                n_sr    = m_sr | 32'h2;
                n_cause = (n_cause & ~32'h8000_007C) | (32'(M_BD) << 31)
                          | (32'(i ? 5'd0 : M_ExcCode) << 2);
                tgt     = M_BD ? M_PC - 4 : M_PC;
                n_epc   = tgt & ~32'h3;
            end else begin
                if (M_Eret) n_sr = m_sr & ~32'h2;
                if (M_CP0We && M_CP0Addr == 5'd12) n_sr = M_CP0WD & 32'h0000_FC03;
                if (M_CP0We && M_CP0Addr == 5'd14) n_epc = M_CP0WD & ~32'h3;
            end
        end
        @(posedge clk);
        #1;
        m_sr = n_sr; m_cause = n_cause; m_epc = n_epc;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic read_reg(input logic [4:0] a, output logic [31:0] d);
        M_CP0Addr = a;
        #1;
        d = CP0RD;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        idle();
        reset = 1'b0;
        M_ExcCode = 5'd3; M_CP0We = 1'b1; M_CP0Addr = 5'd14; M_CP0WD = 32'hABCD;
        tick();
        tick();
        idle();
        reset = 1'b0;
        for (int k = 12; k <= 15; k++) begin
            read_reg(5'(k), d);
            total++;
            if (d !== ((k == 15) ? 32'h2022_1118 : 32'h0)) begin
                bad++; $display("FAIL reset_reg%0d got=%h want=%h", k, d,
                                (k == 15) ? 32'h2022_1118 : 32'h0);
            end
        end
        total++;
        if (Req !== 1'b0 || EPCOut !== 32'h0) begin
            bad++; $display("FAIL reset_outputs req=%b epc=%h want req=0 epc=0", Req, EPCOut);
        end
        reset = 1'b1;
    endtask

    task automatic test_exception();
        logic [31:0] d;
        do_reset();
        M_ExcCode = 5'd10; M_PC = 32'h3008; M_BD = 1'b0;
        #1;
        total++;
        if (Req !== 1'b1 || ReqPC !== 32'h4180) begin
            bad++; $display("FAIL exc_req req=%b reqpc=%h want 1/00004180", Req, ReqPC);
        end
        tick();
        idle();
        read_reg(5'd13, d); total++;
        if (d !== 32'h0000_0028) begin bad++; $display("FAIL exc_cause got=%h want=00000028", d); end
        read_reg(5'd14, d); total++;
        if (d !== 32'h3008) begin bad++; $display("FAIL exc_epc got=%h want=00003008", d); end
        read_reg(5'd12, d); total++;
        if (d !== 32'h2) begin bad++; $display("FAIL exc_sr got=%h want=00000002", d); end
    endtask

    task automatic test_delay_slot();
        logic [31:0] d;
        do_reset();
        M_ExcCode = 5'd4; M_PC = 32'h3010; M_BD = 1'b1;
        tick();
        idle();
        read_reg(5'd14, d); total++;
        if (d !== 32'h300C) begin bad++; $display("FAIL bd_epc got=%h want=0000300c", d); end
        read_reg(5'd13, d); total++;
        if (d !== 32'h8000_0010) begin bad++; $display("FAIL bd_cause got=%h want=80000010", d); end
        do_reset();
        M_ExcCode = 5'd4; M_PC = 32'h0; M_BD = 1'b1;
        tick();
        idle();
        total++;
        if (EPCOut !== 32'hFFFF_FFFC) begin
            bad++; $display("FAIL wrap_epc got=%h want=fffffffc", EPCOut);
        end
    endtask

    task automatic test_int_priority();
        logic [31:0] d;
        do_reset();
        M_CP0We = 1'b1; M_CP0Addr = 5'd12; M_CP0WD = 32'h0000_FC01;
        tick();
        idle();
        HWInt = 6'b000100; M_ExcCode = 5'd12; M_PC = 32'h3100;
        #1;
        total++;
        if (Req !== 1'b1) begin bad++; $display("FAIL int_req got=%b want=1", Req); end
        tick();
        M_ExcCode = 5'd0;
        read_reg(5'd13, d); total++;
        if (d !== 32'h0000_1000) begin bad++; $display("FAIL int_cause got=%h want=00001000", d); end
        M_ExcCode = 5'd12;
        #1;
        total++;
        if (Req !== 1'b0) begin bad++; $display("FAIL int_masked_exl got=%b want=0", Req); end
        tick();
    endtask

    task automatic test_eret();
        logic [31:0] d;
        do_reset();
        M_CP0We = 1'b1; M_CP0Addr = 5'd14; M_CP0WD = 32'h3020;
        tick();
        M_CP0Addr = 5'd12; M_CP0WD = 32'h2;
        tick();
        idle();
        M_Eret = 1'b1;
        #1;
        total++;
        if (Req !== 1'b0 || ReqPC !== 32'h3020) begin
            bad++; $display("FAIL eret_redirect req=%b reqpc=%h want 0/00003020", Req, ReqPC);
        end
        tick();
        M_Eret = 1'b0;
        read_reg(5'd12, d); total++;
        if (d !== 32'h0) begin bad++; $display("FAIL eret_sr got=%h want=00000000", d); end
        M_Eret = 1'b1; M_ExcCode = 5'd5; M_PC = 32'h3024;
        #1;
        total++;
        if (Req !== 1'b1 || ReqPC !== 32'h4180) begin
            bad++; $display("FAIL eret_vs_exc req=%b reqpc=%h want 1/00004180", Req, ReqPC);
        end
        tick();
        idle();
        read_reg(5'd12, d); total++;
        if (d !== 32'h2) begin bad++; $display("FAIL eret_vs_exc_sr got=%h want=00000002", d); end
    endtask

    task automatic test_mtc0_fault();
        logic [31:0] d;
        do_reset();
        M_CP0We = 1'b1; M_CP0Addr = 5'd14; M_CP0WD = 32'h5555;
        M_ExcCode = 5'd4; M_PC = 32'h3040;
        #1;
        total++;
        if (CP0RD !== 32'h0 || EPCOut !== 32'h0) begin
            bad++; $display("FAIL fault_old_read rd=%h epc=%h want 0/0", CP0RD, EPCOut);
        end
        tick();
        idle();
        read_reg(5'd14, d); total++;
        if (d !== 32'h3040) begin bad++; $display("FAIL fault_epc got=%h want=00003040", d); end
    endtask

    task automatic test_reset_mid_handler();
        logic [31:0] d;
        do_reset();
        M_CP0We = 1'b1; M_CP0Addr = 5'd12; M_CP0WD = 32'h0000_FC01;
        tick();
        idle();
        M_ExcCode = 5'd7; M_PC = 32'h3200;
        tick();
        idle();
        reset = 1'b0; M_ExcCode = 5'd9; M_CP0We = 1'b1; M_CP0Addr = 5'd14; M_CP0WD = 32'h7770;
        tick();
        idle();
        for (int k = 12; k <= 14; k++) begin
            read_reg(5'(k), d); total++;
            if (d !== 32'h0) begin bad++; $display("FAIL midrst_reg%0d got=%h want=0", k, d); end
        end
        HWInt = 6'h3F;
        #1;
        total++;
        if (Req !== 1'b0) begin bad++; $display("FAIL midrst_int got=%b want=0", Req); end
        tick();
    endtask

    task automatic test_random();
        logic [4:0] addrs [5];
        addrs[0] = 5'd12; addrs[1] = 5'd13; addrs[2] = 5'd14; addrs[3] = 5'd15; addrs[4] = 5'd3;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            reset     = ($urandom_range(0, 59) != 0);
            M_ExcCode = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
            M_PC      = $urandom;
            M_BD      = 1'($urandom);
            HWInt     = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
            M_Eret    = ($urandom_range(0, 5) == 0);
            M_CP0We   = !M_Eret && ($urandom_range(0, 2) == 0);
            M_CP0Addr = addrs[$urandom_range(0, 4)];
            M_CP0WD   = $urandom;
            #1;
            total++;
            if (Req !== model_req() || ReqPC !== model_reqpc() || EPCOut !== m_epc
                || CP0RD !== model_read(M_CP0Addr)) begin
                bad++;
                $display("FAIL rand[%0d] req=%b/%b reqpc=%h/%h epc=%h/%h rd=%h/%h (got/want)",
                         n, Req, model_req(), ReqPC, model_reqpc(), EPCOut, m_epc,
                         CP0RD, model_read(M_CP0Addr));
            end
            tick();
        end
    endtask

    initial begin
        idle();
        m_sr = 0; m_cause = 0; m_epc = 0;
        test_reset();
        test_exception();
        test_delay_slot();
        test_int_priority();
        test_eret();
        test_mtc0_fault();
        test_reset_mid_handler();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
